alu_ctrl_decode: RTL and testbench

ALU_CTRL_DECODE -- requirements
Module: alu_ctrl_decode

---
 rtl/alu_ctrl_decode.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_ctrl_decode.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode.sv
// RV32I ALU-control decoder behind a two-entry skid buffer.
// Define ALU_CTRL_ILLEGAL_EN to flag unknown encodings on out_illegal.
module alu_ctrl_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_sel,
  output logic [31:0] out_imm,
  output logic        out_b_imm,
  output logic        out_a_pc,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_wr,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef struct packed {
    logic [3:0]  alu_sel;
    logic [31:0] imm;
    logic        b_imm;
    logic        a_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic [31:0] pc;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_n;
  logic   rdy;
  entry_t head, tail, dec;
  logic   in_x, out_x;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  function automatic logic [3:0] alu_map(
    input logic [2:0] fn,
    input logic       alt
  );
    logic [3:0] s;
    case (fn)
      3'b000:  s = alt ? ALU_SUB : ALU_ADD;
      3'b001:  s = ALU_SLL;
      3'b010:  s = ALU_SLT;
      3'b011:  s = ALU_SLTU;
      3'b100:  s = ALU_XOR;
      3'b101:  s = alt ? ALU_SRA : ALU_SRL;
      3'b110:  s = ALU_OR;
      default: s = ALU_AND;
    endcase
    return s;
  endfunction

  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;

  // Combinational decode of the offered instruction
  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.pc  = in_pc;
    unique case (1'b1)
      (opc == 7'b0110011): begin
        dec.alu_sel = alu_map(f3, f7[5]);
        dec.reg_wr  = 1'b1;
        bad = !((f7 == 7'h00) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      (opc == 7'b0010011): begin
        dec.alu_sel = alu_map(f3, (f3 == 3'b101) & f7[5]);
        dec.b_imm   = 1'b1;
        dec.imm     = imm_i;
        dec.reg_wr  = 1'b1;
        bad = ((f3 == 3'b001) && (f7 != 7'h00)) ||
              ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      (opc == 7'b0000011): begin
        dec.b_imm  = 1'b1;
        dec.imm    = imm_i;
        dec.reg_wr = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      (opc == 7'b1100111): begin
        dec.b_imm  = 1'b1;
        dec.imm    = imm_i;
        dec.reg_wr = 1'b1;
        bad = (f3 != 3'b000);
      end
      (opc == 7'b0100011): begin
        dec.b_imm = 1'b1;
        dec.imm   = imm_s;
        bad = (f3 > 3'd2);
      end
      (opc == 7'b1100011): begin
        dec.imm = imm_b;
        case (f3[2:1])
          2'b00:   dec.alu_sel = ALU_SUB;
          2'b10:   dec.alu_sel = ALU_SLT;
          2'b11:   dec.alu_sel = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      (opc == 7'b0110111): begin
        dec.alu_sel = ALU_PASS;
        dec.b_imm   = 1'b1;
        dec.imm     = imm_u;
        dec.reg_wr  = 1'b1;
      end
      (opc == 7'b0010111): begin
        dec.a_pc   = 1'b1;
        dec.b_imm  = 1'b1;
        dec.imm    = imm_u;
        dec.reg_wr = 1'b1;
      end
      (opc == 7'b1101111): begin
        dec.a_pc   = 1'b1;
        dec.b_imm  = 1'b1;
        dec.imm    = imm_j;
        dec.reg_wr = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.alu_sel = ALU_ADD;
      dec.reg_wr  = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
      dec.illegal = 1'b1;
`else
      dec.illegal = 1'b0;
`endif
    end
    if (dec.rd == 5'd0) dec.reg_wr = 1'b0;
  end

  // State register and registered in_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      rdy   <= 1'b0;
    end else begin
      state <= state_n;
      rdy   <= (state_n != TWO);
    end
  end

  // Next-state logic; flush wins over any handshake
  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (in_x) state_n = ONE;
      ONE: begin
        if (in_x && !out_x) state_n = TWO;
        else if (out_x && !in_x) state_n = EMPTY;
      end
      TWO: if (out_x) state_n = ONE;
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end

  // Handshake outputs
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = rdy;
  end

  // Entry storage: head is the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      unique case (state)
        EMPTY: if (in_x) head <= dec;
        ONE: begin
          if (in_x && out_x) head <= dec;
          else if (in_x) tail <= dec;
        end
        TWO: if (out_x) head <= tail;
        default: ;
      endcase
    end
  end

  assign out_alu_sel = head.alu_sel;
  assign out_imm     = head.imm;
  assign out_b_imm   = head.b_imm;
  assign out_a_pc    = head.a_pc;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_reg_wr  = head.reg_wr;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed bench for alu_ctrl_decode.
// Vector table plus hand-written skid-buffer sequences.
module tb_alu_ctrl_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_sel;
  logic [31:0] out_imm;
  logic        out_b_imm;
  logic        out_a_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_wr;
  logic [31:0] out_pc;
  logic        out_illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_decode dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_sel(out_alu_sel), .out_imm(out_imm),
    .out_b_imm(out_b_imm), .out_a_pc(out_a_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_wr(out_reg_wr), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        ck_imm;
    logic [31:0] imm;
    logic        b_imm;
    logic        a_pc;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_wr;
    logic        ill;
  } vec_t;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  vec_t v[15];

  initial begin
    v[0]  = '{"add",   32'h002081B3, 4'b0000, 0, 0, 0, 0, 1, 2, 3, 1, 0};
    v[1]  = '{"sub",   32'h407302B3, 4'b1000, 0, 0, 0, 0, 6, 7, 5, 1, 0};
    v[2]  = '{"srai",  32'h4032D293, 4'b1101, 1, 32'h403, 1, 0, 5, 3, 5, 1, 0};
    v[3]  = '{"lui",   32'hABCDE0B7, 4'b1111, 1, 32'hABCDE000, 1, 0, 27, 28, 1, 1, 0};
    v[4]  = '{"addi",  32'hFFF00093, 4'b0000, 1, 32'hFFFFFFFF, 1, 0, 0, 31, 1, 1, 0};
    v[5]  = '{"nop",   32'h00000013, 4'b0000, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0};
    v[6]  = '{"sw",    32'h0020A423, 4'b0000, 1, 32'h8, 1, 0, 1, 2, 8, 0, 0};
    v[7]  = '{"beq",   32'hFE208EE3, 4'b1000, 1, 32'hFFFFFFFC, 0, 0, 1, 2, 29, 0, 0};
    v[8]  = '{"bltu",  32'h0041E863, 4'b0011, 1, 32'h10, 0, 0, 3, 4, 16, 0, 0};
    v[9]  = '{"auipc", 32'h12345517, 4'b0000, 1, 32'h12345000, 1, 1, 8, 3, 10, 1, 0};
    v[10] = '{"jal",   32'h001000EF, 4'b0000, 1, 32'h800, 1, 1, 0, 1, 1, 1, 0};
    v[11] = '{"or",    32'h009463B3, 4'b0110, 0, 0, 0, 0, 8, 9, 7, 1, 0};
    v[12] = '{"sltiu", 32'h0051B113, 4'b0011, 1, 32'h5, 1, 0, 3, 5, 2, 1, 0};
    v[13] = '{"ones",  32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, 31, 31, 31, 0, ILL};
    v[14] = '{"badf7", 32'h0220C1B3, 4'b0000, 0, 0, 0, 0, 1, 2, 3, 0, ILL};

    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_alu", {28'b0, out_alu_sel}, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_misc", {24'b0, out_b_imm, out_a_pc, out_reg_wr,
                     out_illegal, 4'b0}, 0);
    chk("rst_regs", {17'b0, out_rs1, out_rs2, out_rd}, 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", {31'b0, in_ready}, 1);

    // Decode table, one entry each, drained immediately
    for (int i = 0; i < 15; i++) begin
      send(v[i].instr, 32'h1000 + 32'(i * 4));
      tick();
      in_valid = 1'b0;
      chk({v[i].name, "_valid"}, {31'b0, out_valid}, 1);
      chk({v[i].name, "_alu"}, {28'b0, out_alu_sel}, {28'b0, v[i].alu});
      if (v[i].ck_imm)
        chk({v[i].name, "_imm"}, out_imm, v[i].imm);
      if (v[i].name != "jal")
        chk({v[i].name, "_bimm"}, {31'b0, out_b_imm},
            {31'b0, v[i].b_imm});
      chk({v[i].name, "_apc"}, {31'b0, out_a_pc}, {31'b0, v[i].a_pc});
      chk({v[i].name, "_regs"}, {17'b0, out_rs1, out_rs2, out_rd},
          {17'b0, v[i].rs1, v[i].rs2, v[i].rd});
      chk({v[i].name, "_wr"}, {31'b0, out_reg_wr}, {31'b0, v[i].reg_wr});
      chk({v[i].name, "_ill"}, {31'b0, out_illegal}, {31'b0, v[i].ill});
      chk({v[i].name, "_pc"}, out_pc, 32'h1000 + 32'(i * 4));
      tick();
      chk({v[i].name, "_drain"}, {31'b0, out_valid}, 0);
    end

    // Back-pressure: three offers with out_ready low
    out_ready = 1'b0;
    send(32'h00100093, 32'hA0);
    tick();
    chk("bp_v1", {31'b0, out_valid}, 1);
    chk("bp_rdy1", {31'b0, in_ready}, 1);
    chk("bp_pc1", out_pc, 32'hA0);
    send(32'h00200113, 32'hA4);
    tick();
    chk("bp_rdy2", {31'b0, in_ready}, 0);
    chk("bp_pc2", out_pc, 32'hA0);
    send(32'h00300193, 32'hA8);
    tick();
    chk("bp_rdy3", {31'b0, in_ready}, 0);
    chk("bp_hold_pc", out_pc, 32'hA0);
    chk("bp_hold_rd", {27'b0, out_rd}, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_out2_pc", out_pc, 32'hA4);
    chk("bp_out2_rd", {27'b0, out_rd}, 2);
    chk("bp_rdy4", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out3_pc", out_pc, 32'hA8);
    chk("bp_out3_rd", {27'b0, out_rd}, 3);
    chk("bp_out3_v", {31'b0, out_valid}, 1);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 0);

    // Flush from TWO with an input offered
    out_ready = 1'b0;
    send(32'h00100093, 32'hB0);
    tick();
    send(32'h00200113, 32'hB4);
    tick();
    chk("fl_full", {31'b0, in_ready}, 0);
    send(32'h00300193, 32'hB8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 0);
    chk("fl_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_dropped", {31'b0, out_valid}, 0);
    send(32'h00400213, 32'hBC);
    tick();
    in_valid = 1'b0;
    chk("fl_next_pc", out_pc, 32'hBC);
    chk("fl_next_rd", {27'b0, out_rd}, 4);
    tick();

    // Sustained throughput with out_ready high
    for (int i = 0; i < 4; i++) begin
      send(32'h00000093 | (32'(i + 1) << 7), 32'hC0 + 32'(i * 4));
      tick();
      chk("tp_valid", {31'b0, out_valid}, 1);
      chk("tp_ready", {31'b0, in_ready}, 1);
      chk("tp_pc", out_pc, 32'hC0 + 32'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    chk("tp_empty", {31'b0, out_valid}, 0);

    // Asynchronous reset with an entry held
    out_ready = 1'b0;
    send(32'h00500293, 32'hD0);
    tick();
    in_valid = 1'b0;
    chk("mr_held", {31'b0, out_valid}, 1);
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_ready", {31'b0, in_ready}, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mr_rel_ready", {31'b0, in_ready}, 1);
    chk("mr_rel_valid", {31'b0, out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
